dualboot_arbiter: RTL and testbench

- Round-robin arbiter sharing the 16x8 dual-port RAM (two ports, each with its own address, data in, write enable and registered data out) between NREQ requesters.
- Each cycle it grants up to two requests, one per RAM port.
- When two grants would hit the same address and at least one of them writes, it holds the second request back.
- Read data is steered back to the owning requester with a fixed 2-cycle latency.
- Sits between client logic and the RAM; it is the only master of both RAM ports.

---
 rtl/dualboot_arbiter.sv | 158 +++++++++++++++
 tb/tb_dualboot_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dualboot_arbiter.sv
// Round-robin arbiter that shares a dual-port RAM between NREQ requesters, one grant per port per cycle.
// Optional conflict counter output is enabled by defining DUALBOOT_ARB_STATS_EN.
module dualboot_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 4,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  // Handshake: a requester holds req (with we/addr/wdata stable) until it sees gnt
  // in the same cycle; gnt means the access is taken at the edge ending that cycle.
  // A read is answered later by a one-cycle rvalid pulse; there is no backpressure.
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [NREQ*DW-1:0]   rdata,
  output logic [AW-1:0]        ram_add_a,
  output logic [DW-1:0]        ram_datain_a,
  output logic                 ram_en_a,
  input  logic [DW-1:0]        ram_data_out_a,
  output logic [AW-1:0]        ram_add_b,
  output logic [DW-1:0]        ram_datain_b,
  output logic                 ram_en_b,
  input  logic [DW-1:0]        ram_data_out_b
`ifdef DUALBOOT_ARB_STATS_EN
  ,
  output logic [7:0]           conflict_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] cand;
  logic          found_a, found_b;
  logic [PW-1:0] idx_a, idx_b;
  logic [AW-1:0] addr_a, addr_b;
  logic          conflict;
  logic          grant_a, grant_b;

  logic          tag_a_vld, tag_b_vld;
  logic [PW-1:0] tag_a_idx, tag_b_idx;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return s[PW-1:0];
  endfunction

  // Rotating scan from ptr: first requester goes to port A, second to port B.
  always_comb begin
    found_a = 1'b0;
    found_b = 1'b0;
    idx_a   = '0;
    idx_b   = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_idx(ptr, k);
      if (req[cand]) begin
        if (!found_a) begin
          found_a = 1'b1;
          idx_a   = cand;
        end else if (!found_b) begin
          found_b = 1'b1;
          idx_b   = cand;
        end
      end
    end
  end

  assign addr_a = addr[idx_a*AW +: AW];
  assign addr_b = addr[idx_b*AW +: AW];

  // Same-address pairs involving a write are serialised; read-read pairs may share.
  assign conflict = found_a && found_b && (addr_a == addr_b) && (we[idx_a] || we[idx_b]);
  assign grant_a  = found_a && !rst;
  assign grant_b  = found_b && !conflict && !rst;

  always_comb begin
    gnt = '0;
    if (grant_a) gnt[idx_a] = 1'b1;
    if (grant_b) gnt[idx_b] = 1'b1;
  end

  always_comb begin
    ram_add_a    = '0;
    ram_datain_a = '0;
    ram_en_a     = 1'b0;
    ram_add_b    = '0;
    ram_datain_b = '0;
    ram_en_b     = 1'b0;
    if (grant_a) begin
      ram_add_a    = addr_a;
      ram_datain_a = wdata[idx_a*DW +: DW];
      ram_en_a     = we[idx_a];
    end
    if (grant_b) begin
      ram_add_b    = addr_b;
      ram_datain_b = wdata[idx_b*DW +: DW];
      ram_en_b     = we[idx_b];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_a) begin
      ptr <= wrap_idx(grant_b ? idx_b : idx_a, 1);
    end
  end

  // Port tags remember which requester owns the RAM output arriving next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_a_vld <= 1'b0;
      tag_b_vld <= 1'b0;
      tag_a_idx <= '0;
      tag_b_idx <= '0;
    end else begin
      tag_a_vld <= grant_a && !we[idx_a];
      tag_b_vld <= grant_b && !we[idx_b];
      tag_a_idx <= idx_a;
      tag_b_idx <= idx_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= '0;
      if (tag_a_vld) begin
        rvalid[tag_a_idx]            <= 1'b1;
        rdata[tag_a_idx*DW +: DW]    <= ram_data_out_a;
      end
      if (tag_b_vld) begin
        rvalid[tag_b_idx]            <= 1'b1;
        rdata[tag_b_idx*DW +: DW]    <= ram_data_out_b;
      end
    end
  end

`ifdef DUALBOOT_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != 8'hFF)) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dualboot_arbiter.sv
// Bench for dualboot_arbiter: RAM model, directed scenarios, then random traffic against a queue-based reference.
module tb_dualboot_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 4;
  localparam int DW   = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req, we;
  logic [NREQ*AW-1:0]  addr;
  logic [NREQ*DW-1:0]  wdata;
  logic [NREQ-1:0]     gnt, rvalid;
  logic [NREQ*DW-1:0]  rdata;
  logic [AW-1:0]       ram_add_a, ram_add_b;
  logic [DW-1:0]       ram_datain_a, ram_datain_b;
  logic                ram_en_a, ram_en_b;
  logic [DW-1:0]       ram_data_out_a, ram_data_out_b;
`ifdef DUALBOOT_ARB_STATS_EN
  logic [7:0]          conflict_cnt;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dualboot_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_add_a(ram_add_a), .ram_datain_a(ram_datain_a), .ram_en_a(ram_en_a),
    .ram_data_out_a(ram_data_out_a),
    .ram_add_b(ram_add_b), .ram_datain_b(ram_datain_b), .ram_en_b(ram_en_b),
    .ram_data_out_b(ram_data_out_b)
`ifdef DUALBOOT_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  function automatic logic [DW-1:0] init_val(input int i);
    logic [DW-1:0] v;
    v = 8'h3C ^ 8'(i * 37);
    return v;
  endfunction

  // 16x8 dual-port RAM with registered outputs
  logic          ram_load;
  logic [DW-1:0] ram [16];
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_val(i);
      ram_data_out_a <= '0;
      ram_data_out_b <= '0;
    end else begin
      if (ram_en_a) ram[ram_add_a] <= ram_datain_a;
      if (ram_en_b) ram[ram_add_b] <= ram_datain_b;
      ram_data_out_a <= ram[ram_add_a];
      ram_data_out_b <= ram[ram_add_b];
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] due;
    logic [7:0]  idx;
    logic [7:0]  data;
  } rd_t;

  rd_t             exp_q[$];
  logic [DW-1:0]   m_mem [16];
  logic [DW-1:0]   exp_rdata [NREQ];
  int              m_ptr;
  int              m_cnt;
  int              cyc;
  logic [NREQ-1:0] last_gnt;
  logic [AW-1:0]   last_add_a;
  logic            en_b_seen;
  int              n_checks = 0;
  int              n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] a_of(input int i);
    return addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] d_of(input int i);
    return wdata[i*DW +: DW];
  endfunction

  // Reference: list requesters in rotating order; first two form the candidate pair.
  task automatic model_grant(output logic [NREQ-1:0] g, output int ia, output int ib, output bit blk);
    int found[$];
    g = '0; ia = -1; ib = -1; blk = 0;
    if (!rst) begin
      for (int k = 0; k < NREQ; k++)
        if (req[(m_ptr + k) % NREQ]) found.push_back((m_ptr + k) % NREQ);
      if (found.size() > 0) begin
        ia = found[0];
        g[ia] = 1'b1;
      end
      if (found.size() > 1) begin
        if (a_of(found[0]) == a_of(found[1]) && (we[found[0]] || we[found[1]])) blk = 1;
        else begin
          ib = found[1];
          g[ib] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_port(input string p, input int i, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic e);
    if (i >= 0) begin
      check_val({p, "_add"}, a, a_of(i));
      check_val({p, "_din"}, d, d_of(i));
      check_val({p, "_en"},  e, we[i]);
    end else begin
      check_val({p, "_add"}, a, 0);
      check_val({p, "_din"}, d, 0);
      check_val({p, "_en"},  e, 0);
    end
  endtask

  // One clock cycle: check combinational outputs, advance the model, then check registered outputs.
  task automatic step();
    logic [NREQ-1:0] g, ev;
    int ia, ib;
    bit blk;
    #1;
    model_grant(g, ia, ib, blk);
    check_val("gnt", gnt, g);
    check_port("port_a", ia, ram_add_a, ram_datain_a, ram_en_a);
    check_port("port_b", ib, ram_add_b, ram_datain_b, ram_en_b);
`ifdef DUALBOOT_ARB_STATS_EN
    check_val("conflict_cnt", conflict_cnt, m_cnt);
`endif
    last_gnt   = gnt;
    last_add_a = ram_add_a;
    en_b_seen  = en_b_seen | ram_en_b;
    if (rst) begin
      m_ptr = 0;
      m_cnt = 0;
      exp_q.delete();
      for (int i = 0; i < NREQ; i++) exp_rdata[i] = '0;
    end else begin
      if (blk && m_cnt < 255) m_cnt++;
      if (ia >= 0 && !we[ia]) exp_q.push_back('{due: cyc + 2, idx: 8'(ia), data: m_mem[a_of(ia)]});
      if (ib >= 0 && !we[ib]) exp_q.push_back('{due: cyc + 2, idx: 8'(ib), data: m_mem[a_of(ib)]});
      if (ia >= 0 && we[ia]) m_mem[a_of(ia)] = d_of(ia);
      if (ib >= 0 && we[ib]) m_mem[a_of(ib)] = d_of(ib);
      if (ia >= 0) m_ptr = ((ib >= 0 ? ib : ia) + 1) % NREQ;
    end
    @(posedge clk);
    cyc++;
    #1;
    ev = '0;
    for (int j = exp_q.size() - 1; j >= 0; j--) begin
      if (exp_q[j].due == cyc) begin
        ev[exp_q[j].idx] = 1'b1;
        exp_rdata[exp_q[j].idx] = exp_q[j].data;
        exp_q.delete(j);
      end
    end
    check_val("rvalid", rvalid, ev);
    for (int i = 0; i < NREQ; i++)
      check_val($sformatf("rdata%0d", i), rdata[i*DW +: DW], exp_rdata[i]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ram_load = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0;
    cyc = 0; m_ptr = 0; m_cnt = 0; last_gnt = '0; last_add_a = '0; en_b_seen = 1'b0;
    for (int i = 0; i < 16; i++) m_mem[i] = init_val(i);
    for (int i = 0; i < NREQ; i++) exp_rdata[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    ram_load = 1'b0;
    check_val("rst_rvalid", rvalid, 0);
    check_val("rst_rdata", rdata, 0);
    check_val("rst_gnt", gnt, 0);
    check_val("rst_en_a", ram_en_a, 0);
    do_reset();

    // single requester: write then read back
    en_b_seen = 1'b0;
    req = '0; set_req(0, 1'b1, 4'd3, 8'hA5); step();
    check_val("t1_gnt_wr", last_gnt, 4'b0001);
    req = '0; set_req(0, 1'b0, 4'd3, 8'h00); step();
    check_val("t1_gnt_rd", last_gnt, 4'b0001);
    idle(1);
    check_val("t1_rvalid", rvalid, 4'b0001);
    check_val("t1_rdata", rdata[7:0], 8'hA5);
    idle(2);
    check_val("t1_en_b", en_b_seen, 1'b0);

    // four distinct reads, served in two pairs
    do_reset();
    req = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 4'(i), 8'h00);
    step();
    check_val("t2_gnt1", last_gnt, 4'b0011);
    req[0] = 1'b0; req[1] = 1'b0;
    step();
    check_val("t2_gnt2", last_gnt, 4'b1100);
    check_val("t2_rv1", rvalid, 4'b0011);
    idle(1);
    check_val("t2_rv2", rvalid, 4'b1100);
    idle(1);

    // write-write conflict on one address
    do_reset();
    req = '0; set_req(0, 1'b1, 4'd5, 8'h11); set_req(1, 1'b1, 4'd5, 8'h22); step();
    check_val("t3_gnt1", last_gnt, 4'b0001);
    req[0] = 1'b0; step();
    check_val("t3_gnt2", last_gnt, 4'b0010);
    req = '0; set_req(0, 1'b0, 4'd5, 8'h00); step();
    idle(2);
    check_val("t3_rdata", rdata[7:0], 8'h22);
`ifdef DUALBOOT_ARB_STATS_EN
    check_val("t3_cnt", conflict_cnt, 8'd1);
`endif

    // read-read sharing an address
    do_reset();
    req = '0; set_req(2, 1'b0, 4'd7, 8'h00); set_req(3, 1'b0, 4'd7, 8'h00); step();
    check_val("t4_gnt", last_gnt, 4'b1100);
    idle(1);
    check_val("t4_rvalid", rvalid, 4'b1100);
    check_val("t4_rdata2", rdata[23:16], init_val(7));
    check_val("t4_rdata3", rdata[31:24], init_val(7));
    idle(1);

    // reset right after a read grant
    req = '0; set_req(1, 1'b0, 4'd2, 8'h00); step();
    rst = 1'b1; req = '0; step();
    rst = 1'b0;
    check_val("t5_rv_rst", rvalid, 0);
    step();
    check_val("t5_rv_after", rvalid, 0);
    req = '0; set_req(1, 1'b0, 4'd9, 8'h00); set_req(3, 1'b0, 4'd10, 8'h00); step();
    check_val("t5_gnt", last_gnt, 4'b1010);
    check_val("t5_add_a", last_add_a, 4'd9);
    idle(3);

    // random traffic with occasional withdrawals and resets
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && !last_gnt[i]) begin
          if ($urandom_range(0, 9) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) != 0) begin
          set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 8'($urandom));
        end else begin
          req[i] = 1'b0;
        end
      end
      step();
    end
    rst = 1'b0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
